// File: rtl/laser_lane_tx_if.sv
// Per-lane word handshake between the sample/queue logic (master) and the
// laser lane transmitter (slave). Lane i payload sits at [i*DATA_W +: DATA_W].
interface laser_lane_tx_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 8
);
  logic [LANES*DATA_W-1:0] data_in;
  logic [LANES-1:0]        data_valid;
  logic [LANES-1:0]        data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/laser_lane_tx.sv
// Multi-lane UART-style laser transmitter. Each lane independently accepts a
// DATA_W-bit word and sends start, data LSB-first, optional parity and stop
// bits, each held for a bit period latched from `divider` at acceptance.
// Build option: define LASER_LANE_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module laser_lane_tx #(
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [DIV_W-1:0]     divider,
  laser_lane_tx_if.slave       bus,
  output logic [2*LANES-1:0]   laser_out,
  output logic [LANES-1:0]     busy,
  output logic [LANES-1:0]     done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Holding reset also silences the lasers and the ready flags.
  logic live;
  assign live = en & reset_n;

  // A zero divider would stall the bit counter, so it behaves as one.
  logic [DIV_W-1:0] period;
  assign period = (divider == '0) ? DIV_W'(1) : divider;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  per;
    logic [DIV_W-1:0]  cnt;
    logic [BIT_W-1:0]  idx;
    logic [DATA_W-1:0] word;
    logic              done_q;
    logic              accept;
    logic              bit_end;
    logic              line;
    logic              ready_l;
    logic              busy_l;
    logic [1:0]        pair;

    assign accept  = bus.data_valid[i] & ready_l;
    assign bit_end = (cnt == per - DIV_W'(1));

    // State register; dropping en abandons the frame on the next edge.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state <= S_IDLE;
      end else begin
        state <= state_nx;
      end
    end

    // Next-state: every non-idle state lasts one latched bit period.
    always_comb begin
      state_nx = state;
      if (!en) begin
        state_nx = S_IDLE;
      end else begin
        case (state)
          S_IDLE:   if (accept) state_nx = S_START;
          S_START:  if (bit_end) state_nx = S_DATA;
          S_DATA: begin
            if (bit_end && (idx == BIT_W'(DATA_W - 1))) begin
`ifdef LASER_LANE_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end
          end
          S_PARITY: if (bit_end) state_nx = S_STOP;
          S_STOP:   if (bit_end) state_nx = S_IDLE;
          default:  state_nx = S_IDLE;
        endcase
      end
    end

    // Payload/period capture, cycle and bit counters, end-of-frame flag.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        per    <= '0;
        cnt    <= '0;
        idx    <= '0;
        word   <= '0;
        done_q <= 1'b0;
      end else begin
        done_q <= en && (state == S_STOP) && bit_end;
        if (!en) begin
          cnt <= '0;
          idx <= '0;
        end else if (state == S_IDLE) begin
          cnt <= '0;
          idx <= '0;
          if (accept) begin
            word <= bus.data_in[i*DATA_W +: DATA_W];
            per  <= period;
          end
        end else if (bit_end) begin
          cnt <= '0;
          if (state == S_DATA) idx <= idx + BIT_W'(1);
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end

    // Line level per state, laser pair, and handshake/status flags.
    always_comb begin
      line = 1'b1;
      case (state)
        S_START:  line = 1'b0;
        S_DATA:   line = word[idx];
        S_PARITY: line = ^word;
        default:  line = 1'b1;
      endcase
      pair    = live ? {line, ~line} : 2'b00;
      ready_l = live && (state == S_IDLE);
      busy_l  = (state != S_IDLE);
    end

    assign bus.data_ready[i]   = ready_l;
    assign busy[i]             = busy_l;
    assign done[i]             = done_q;
    assign laser_out[2*i +: 2] = pair;
  end

endmodule

// File: tb/tb_laser_lane_tx.sv
// Bench for laser_lane_tx: directed and randomized frames compared cycle by
// cycle against a frame-level model of the expected line waveform.
module tb_laser_lane_tx;
  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
`ifdef LASER_LANE_PARITY_EN
  localparam int NB = DATA_W + 3;
`else
  localparam int NB = DATA_W + 2;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 en = 1'b0;
  logic [DIV_W-1:0]     divider = '0;
  logic [2*LANES-1:0]   laser_out;
  logic [LANES-1:0]     busy;
  logic [LANES-1:0]     done;
  int total = 0;
  int bad = 0;

  laser_lane_tx_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  laser_lane_tx #(.LANES(LANES), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .en(en),
    .divider(divider),
    .bus(bus),
    .laser_out(laser_out),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit n: start, payload LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n <= DATA_W) return d[n-1];
`ifdef LASER_LANE_PARITY_EN
    if (n == DATA_W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Offer words on the masked lanes now (at a falling edge), then check every
  // cycle from the first START cycle through the done cycle.
  task automatic frame(input logic [LANES-1:0] mask, input logic [7:0] d0,
                       input logic [7:0] d1, input int div, input int new_div,
                       input bit hold);
    int p;
    int len;
    logic [7:0] d [0:1];
    logic line;
    logic [2*LANES-1:0] exp_out;
    logic [LANES-1:0] exp_busy;
    logic [LANES-1:0] exp_done;
    logic [LANES-1:0] exp_rdy;
    logic [LANES-1:0] got_rdy;
    p = (div == 0) ? 1 : div;
    len = NB * p;
    d[0] = d0;
    d[1] = d1;
    bus.data_in = {d1, d0};
    bus.data_valid = mask;
    divider = DIV_W'(div);
    got_rdy = bus.data_ready & mask;
    chk("ready_before_accept", got_rdy, mask);
    @(posedge clock);
    @(negedge clock);
    if (!hold) bus.data_valid = '0;
    for (int k = 0; k <= len; k++) begin
      if (k == 1) divider = DIV_W'(new_div);
      for (int l = 0; l < LANES; l++) begin
        line = (mask[l] && k < len) ? frame_bit(d[l], k / p) : 1'b1;
        exp_out[2*l +: 2] = {line, ~line};
        exp_busy[l] = mask[l] && (k < len);
        exp_done[l] = mask[l] && (k == len);
      end
      exp_rdy = ~exp_busy;
      chk("laser_out", laser_out, exp_out);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("data_ready", bus.data_ready, exp_rdy);
      if (k < len) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk("idle_laser", laser_out, 4'b1010);
      chk("idle_busy", busy, 2'b00);
      chk("idle_done", done, 2'b00);
    end
  endtask

  initial begin
    logic [7:0] r0;
    logic [7:0] r1;
    bus.data_in = '0;
    bus.data_valid = '0;
    en = 1'b1;
    divider = DIV_W'(4);

    // Reset held: everything quiet even with en high.
    repeat (2) @(negedge clock);
    chk("rst_laser", laser_out, 4'b0000);
    chk("rst_ready", bus.data_ready, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_done", done, 2'b00);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", bus.data_ready, 2'b11);
    chk("post_rst_laser", laser_out, 4'b1010);

    // Single lane, P=4, payload 0x08.
    frame(2'b01, 8'h08, 8'h00, 4, 4, 1'b0);
    idle(3);
    // Both lanes together, P=1.
    frame(2'b11, 8'h08, 8'hFF, 1, 1, 1'b0);
    idle(2);
    // Divider 0 acts as 1.
    frame(2'b01, 8'hA5, 8'h00, 0, 0, 1'b0);
    idle(1);
    // Divider changed mid-frame: current frame keeps P=4, next uses P=8.
    frame(2'b01, 8'h3C, 8'h00, 4, 8, 1'b0);
    idle(2);
    frame(2'b10, 8'h00, 8'hC3, 8, 8, 1'b0);
    idle(1);
    // Valid held high: frames back to back, accept in the done cycle.
    frame(2'b01, 8'h5A, 8'h00, 2, 2, 1'b1);
    frame(2'b01, 8'h96, 8'h00, 2, 2, 1'b1);
    frame(2'b01, 8'h0F, 8'h00, 2, 2, 1'b0);
    idle(1);
    // Parity-relevant payloads.
    frame(2'b01, 8'h07, 8'h00, 2, 2, 1'b0);
    idle(1);
    frame(2'b01, 8'h03, 8'h00, 2, 2, 1'b0);
    idle(1);

    // Drop en during data bit 3 (P=2: START cycles 0-1, bit 3 at cycle 8).
    bus.data_in = {8'h00, 8'hB6};
    bus.data_valid = 2'b01;
    divider = DIV_W'(2);
    @(posedge clock);
    @(negedge clock);
    bus.data_valid = '0;
    repeat (8) @(negedge clock);
    r0 = 8'hB6;
    chk("bit3_line", laser_out[1:0], {r0[3], ~r0[3]});
    en = 1'b0;
    @(negedge clock);
    chk("abort_laser", laser_out, 4'b0000);
    chk("abort_busy", busy, 2'b00);
    chk("abort_done", done, 2'b00);
    chk("abort_ready", bus.data_ready, 2'b00);
    bus.data_valid = 2'b11;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock);
      chk("off_done", done, 2'b00);
      chk("off_busy", busy, 2'b00);
      chk("off_laser", laser_out, 4'b0000);
    end
    bus.data_valid = '0;
    en = 1'b1;
    #1;
    chk("reen_ready", bus.data_ready, 2'b11);
    chk("reen_laser", laser_out, 4'b1010);
    idle(2);

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      frame(2'($urandom_range(1, 3)), r0, r1, int'($urandom_range(0, 5)),
            int'($urandom_range(0, 5)), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a frame.
    bus.data_in = {8'h00, 8'h81};
    bus.data_valid = 2'b01;
    divider = DIV_W'(3);
    @(posedge clock);
    @(negedge clock);
    bus.data_valid = '0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_laser", laser_out, 4'b0000);
    chk("async_rst_busy", busy, 2'b00);
    chk("async_rst_ready", bus.data_ready, 2'b00);
    chk("async_rst_done", done, 2'b00);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("after_rst_ready", bus.data_ready, 2'b11);
    chk("after_rst_laser", laser_out, 4'b1010);
    chk("after_rst_busy", busy, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/laser_lane_tx.md
Name: laser_lane_tx

Overview:
- Parametrised multi-lane laser transmitter; successor to the fixed two-lane, fixed-byte transmitter in the FPGA top level.
- Serialises one DATA_W-bit word per lane into a UART-style frame (start, data LSB-first, stop) at a runtime-programmable baud divider.
- Each lane has an independent valid/ready handshake and drives a complementary laser pair.
- Sits between the sample/queue logic and the GPIO laser drivers.

Parameters:
- LANES, 2, number of independent laser lanes (1..8).
- DATA_W, 8, payload bits per frame.
- DIV_W, 8, width of the baud divider input.

Ports:
- clock  input  1  system clock (CLOCK_50 domain).
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low forces lasers off and aborts frames.
- divider  input  DIV_W  clock cycles per bit; 0 treated as 1.
- data_in  input  LANES*DATA_W  lane i payload at [i*DATA_W +: DATA_W].
- data_valid  input  LANES  per-lane word-offered strobe.
- data_ready  output  LANES  per-lane accept-ready.
- laser_out  output  2*LANES  lane i pair at [2i+1:2i] = {line, ~line}.
- busy  output  LANES  lane i in a frame.
- done  output  LANES  one-cycle pulse per completed frame.

Behaviour:
- Reset (async, reset_n=0): all lanes IDLE; data_ready=0, busy=0, done=0, laser_out=0; counters and shift registers cleared.
- Per-lane FSM: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP, see Optional Feature).
- data_ready[i] = en && state_i==IDLE (combinational from registered state).
- Accept when data_valid[i] && data_ready[i] at a rising edge. At that edge:
  - latch the payload;
  - latch max(divider,1) as the lane's bit period P;
  - clear the bit counter;
  - move to START.
- The first START cycle on laser_out is the cycle after acceptance.
- Each non-IDLE state lasts exactly P cycles, counted by a per-lane cycle counter 0..P-1. The state advances on the edge where the counter equals P-1.
- DATA lasts DATA_W bit periods, LSB first; a bit index counts 0..DATA_W-1.
- Line level: IDLE=1, START=0, DATA=payload bit, STOP=1.
- laser_out pair:
  - {line,~line} while en=1 (IDLE therefore shows 2'b10);
  - 2'b00 while en=0.
- Frame length = (DATA_W+2)*P cycles (plus P with parity).
- done[i] is high for exactly the first cycle back in IDLE. data_ready is also high in that cycle, so a back-to-back accept there is legal; the next START then follows with zero idle bit periods.
- busy[i] = state_i != IDLE.
- divider changes mid-frame are ignored; they take effect at the next acceptance.
- en deasserted mid-frame: the lane returns to IDLE on the next edge, no done pulse, the frame is lost, laser_out=0 from that cycle.
- Lanes are fully independent: simultaneous accepts, different lengths and overlapping done pulses are all legal.
- data_valid while not ready is ignored. The source must hold data until ready; there is no internal queue.

Optional Feature:
- Macro LASER_LANE_PARITY_EN.
- Defined: a PARITY state of P cycles is inserted after DATA, driving even parity (XOR of the payload). Frame length becomes (DATA_W+3)*P.
- Undefined: no PARITY state; frame length is (DATA_W+2)*P.
- All ports are identical in both builds.

Test Plan:
- Reset, then LANES=2, DATA_W=8, divider=4, en=1, lane0 sends 0x08 -> lane0 line sequence 0,0,0,0,1,0,0,0,0,1, each held 4 cycles; done[0] pulses 40 cycles after the first START cycle; laser_out[1:0] idle=2'b10; lane1 stays 2'b10 throughout.
- Both lanes accept in the same cycle (0x08, 0xFF) with divider=1 -> both frames are 10 cycles; done=2'b11 in the same cycle; lane1 line 0,1,1,1,1,1,1,1,1,1.
- divider=0 -> behaves as divider=1 (10-cycle frame). Change divider 4->8 mid-frame -> current frame stays at P=4; the next frame uses P=8.
- Drop en during DATA bit 3 -> next cycle laser_out=0, busy=0, no done, data_ready=0. Raise en -> data_ready=1, line idle=1.
- Hold data_valid continuously with divider=2 -> frames back-to-back; done and accept in the same cycle; START immediately follows STOP with no idle bit.
- LASER_LANE_PARITY_EN defined, payload 0x07, divider=2 -> parity bit 1 after DATA; done after 22 cycles. Payload 0x03 -> parity bit 0.
